// File: rtl/mac_requant_fifo_if.sv
// mac_requant_fifo_if
//   Bundles the MAC-result input and the drained output of mac_requant_fifo.
//   master : producer/consumer side (testbench or the surrounding datapath)
//   slave  : mac_requant_fifo itself
// Signals
//   IN_VALID   MAC DONE level; a sample is taken on its rising edge
//   IN_DATA    MAC MOUT, sign-magnitude, IN_BITWIDTH bits
//   OUT_DATA   FIFO head, sign-magnitude, OUT_BITWIDTH bits (0 when empty)
//   OUT_VALID  FIFO non-empty
//   OUT_READY  consumer pops the head when OUT_VALID && OUT_READY
//   FULL       FIFO holds FIFO_DEPTH entries
//   SAT        sticky: an accepted sample saturated
//   OVERFLOW   sticky: a sample was dropped on a full FIFO
interface mac_requant_fifo_if #(
  parameter int IN_BITWIDTH  = 16,
  parameter int OUT_BITWIDTH = 8
);
  logic                    IN_VALID;
  logic [IN_BITWIDTH-1:0]  IN_DATA;
  logic [OUT_BITWIDTH-1:0] OUT_DATA;
  logic                    OUT_VALID;
  logic                    OUT_READY;
  logic                    FULL;
  logic                    SAT;
  logic                    OVERFLOW;

  modport master (
    output IN_VALID, IN_DATA, OUT_READY,
    input  OUT_DATA, OUT_VALID, FULL, SAT, OVERFLOW
  );

  modport slave (
    input  IN_VALID, IN_DATA, OUT_READY,
    output OUT_DATA, OUT_VALID, FULL, SAT, OVERFLOW
  );
endinterface

// File: rtl/mac_requant_fifo.sv
// mac_requant_fifo
//   Downstream stage of the sign-magnitude MAC. Captures each MAC result on
//   the rising edge of DONE, requantizes it (round half away from zero,
//   saturate) from 1.15 sign-magnitude with 12 fraction bits to 1.7
//   sign-magnitude with 6 fraction bits, and queues it in a small FIFO with
//   a valid/ready drain.
// Ports
//   CLK  clock, all state on the rising edge
//   RST  asynchronous active-high reset
//   bus  mac_requant_fifo_if.slave (IN_VALID/IN_DATA in, OUT_* / FULL /
//        SAT / OVERFLOW out, OUT_READY in)
// Optional build macro
//   MAC_REQUANT_RELU_EN : negative samples convert to 0x00 (never saturate)
//
// stage   | meaning
// S_CAP   | edge seen, IN_DATA latched into cap_data (cap_v)
// S_CONV  | requantized word registered into conv_word (conv_v)
// S_PUSH  | conv_word written into the FIFO, or dropped if it is full
module mac_requant_fifo #(
  parameter int IN_BITWIDTH  = 16,
  parameter int OUT_BITWIDTH = 8,
  parameter int SHIFT        = 6,
  parameter int FIFO_DEPTH   = 4
) (
  input logic             CLK,
  input logic             RST,
  mac_requant_fifo_if.slave bus
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int MAG_IN  = IN_BITWIDTH - 1;
  localparam int MAG_OUT = OUT_BITWIDTH - 1;
  // rounding can carry one bit past the shifted magnitude
  localparam int R_W     = MAG_IN - SHIFT + 1;

  logic                    in_prev;
  logic                    armed;
  logic                    accept;
  logic                    cap_v;
  logic [IN_BITWIDTH-1:0]  cap_data;
  logic                    conv_v;
  logic                    conv_sat;
  logic [OUT_BITWIDTH-1:0] conv_word;
  logic [OUT_BITWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    sat_q;
  logic                    ovf_q;
  logic                    pop;
  logic                    push;
  logic                    not_empty;

  logic [MAG_IN-1:0]       mag_in;
  logic                    neg;
  logic [R_W-1:0]          r;
  logic                    over;
  logic [MAG_OUT-1:0]      mag_out;
  logic [OUT_BITWIDTH-1:0] word;

  always_comb begin
    mag_in  = cap_data[MAG_IN-1:0];
    neg     = cap_data[IN_BITWIDTH-1];
    r       = R_W'(mag_in >> SHIFT) + R_W'(mag_in[SHIFT-1]);
    over    = r > R_W'((1 << MAG_OUT) - 1);
    mag_out = over ? '1 : r[MAG_OUT-1:0];
`ifdef MAC_REQUANT_RELU_EN
    if (neg) begin
      mag_out = '0;
      over    = 1'b0;
    end
`endif
    // a zero magnitude always leaves with a positive sign
    word = {neg && (mag_out != '0), mag_out};
  end

  // armed stays low after reset until IN_VALID has been seen low, so a level
  // that is already high when reset releases is not taken as an edge
  assign accept    = bus.IN_VALID && !in_prev && armed;
  assign not_empty = (count != '0);
  assign pop       = not_empty && bus.OUT_READY;
  assign push      = conv_v && ((count < CNT_W'(FIFO_DEPTH)) || pop);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      in_prev   <= 1'b0;
      armed     <= 1'b0;
      cap_v     <= 1'b0;
      cap_data  <= '0;
      conv_v    <= 1'b0;
      conv_sat  <= 1'b0;
      conv_word <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      in_prev <= bus.IN_VALID;
      armed   <= armed | ~bus.IN_VALID;

      cap_v <= accept;
      if (accept) cap_data <= bus.IN_DATA;

      conv_v <= cap_v;
      if (cap_v) begin
        conv_word <= word;
        conv_sat  <= over;
      end

      if (conv_v) begin
        if (conv_sat) sat_q <= 1'b1;
        if (!push)    ovf_q <= 1'b1;
      end

      // on a full FIFO with a pop, wr_ptr == rd_ptr: the head is overwritten
      // only after it has been consumed this cycle
      if (push) begin
        mem[wr_ptr] <= conv_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.OUT_VALID = not_empty;
  assign bus.FULL      = (count == CNT_W'(FIFO_DEPTH));
  assign bus.OUT_DATA  = not_empty ? mem[rd_ptr] : '0;
  assign bus.SAT       = sat_q;
  assign bus.OVERFLOW  = ovf_q;
endmodule
